// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and MEM/WB operand forwarding.
// Bubbles (flush, stall, invalid decode, reset) zero every E-stage field, including Rs1E/Rs2E.
module id_ex_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [3:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            FlushE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [4:0]      RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      RdW,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [3:0]      ALUControlE,
    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic            StallD
);

    logic            alusrc_e;
    logic [4:0]      rs1_e, rs2_e;
    logic [XLEN-1:0] rd1_e, rd2_e;
    logic [XLEN-1:0] fwd_a, fwd_b;
    logic            bubble;

    // A load in E whose destination is read by the instruction in D must wait one cycle.
    assign StallD = ValidE && (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                    ValidD && ((RdE == Rs1D) || (RdE == Rs2D));

    assign bubble = FlushE || StallD || !ValidD;

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 4'b0000;
            alusrc_e    <= 1'b0;
            RdE         <= 5'd0;
            rs1_e       <= 5'd0;
            rs2_e       <= 5'd0;
            rd1_e       <= '0;
            rd2_e       <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
        end else begin
            ValidE      <= 1'b1;
            RegWriteE   <= RegWriteD;
            MemWriteE   <= MemWriteD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            alusrc_e    <= ALUSrcD;
            RdE         <= RdD;
            rs1_e       <= Rs1D;
            rs2_e       <= Rs2D;
            rd1_e       <= RD1D;
            rd2_e       <= RD2D;
            ImmExtE     <= ImmExtD;
            PCE         <= PCD;
        end
    end

    // MEM result is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_a = rd1_e;
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs1_e))
            fwd_a = ALUResultM;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs1_e))
            fwd_a = ResultW;
    end

    always_comb begin
        fwd_b = rd2_e;
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs2_e))
            fwd_b = ALUResultM;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs2_e))
            fwd_b = ResultW;
    end

    assign SrcAE      = fwd_a;
    assign WriteDataE = fwd_b;
    assign SrcBE      = alusrc_e ? ImmExtE : fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of single-cycle vectors plus stall/flush/reset sequences.
module tb_id_ex_stage;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ValidD;
    logic [63:0]     RD1D, RD2D, ImmExtD, PCD;
    logic [4:0]      Rs1D, Rs2D, RdD;
    logic [3:0]      ALUControlD;
    logic            ALUSrcD, RegWriteD, MemWriteD;
    logic [1:0]      ResultSrcD;
    logic            FlushE;
    logic [63:0]     ALUResultM;
    logic [4:0]      RdM;
    logic            RegWriteM;
    logic [63:0]     ResultW;
    logic [4:0]      RdW;
    logic            RegWriteW;
    logic [63:0]     SrcAE, SrcBE, WriteDataE;
    logic [3:0]      ALUControlE;
    logic            ValidE, RegWriteE, MemWriteE;
    logic [1:0]      ResultSrcE;
    logic [4:0]      RdE;
    logic [63:0]     PCE, ImmExtE;
    logic            StallD;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .ResultSrcD(ResultSrcD), .FlushE(FlushE),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
        .ALUControlE(ALUControlE), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .RdE(RdE),
        .PCE(PCE), .ImmExtE(ImmExtE), .StallD(StallD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [63:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  aluc;
        logic        alusrc, regw, memw;
        logic [1:0]  rsrc;
        logic        flush;
        logic [63:0] alu_m;
        logic [4:0]  rd_m;
        logic        regw_m;
        logic [63:0] res_w;
        logic [4:0]  rd_w;
        logic        regw_w;
        logic [63:0] x_srca, x_srcb, x_wdata, x_pc, x_imm;
        logic        x_valid, x_regw, x_memw;
        logic [4:0]  x_rd;
        logic [3:0]  x_aluc;
        logic [1:0]  x_rsrc;
    } vec_t;

    function automatic vec_t zv();
        vec_t v;
        v.valid = 0; v.rd1 = 0; v.rd2 = 0; v.imm = 0; v.pc = 0;
        v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.aluc = 0;
        v.alusrc = 0; v.regw = 0; v.memw = 0; v.rsrc = 0; v.flush = 0;
        v.alu_m = 0; v.rd_m = 0; v.regw_m = 0; v.res_w = 0; v.rd_w = 0; v.regw_w = 0;
        v.x_srca = 0; v.x_srcb = 0; v.x_wdata = 0; v.x_pc = 0; v.x_imm = 0;
        v.x_valid = 0; v.x_regw = 0; v.x_memw = 0; v.x_rd = 0; v.x_aluc = 0; v.x_rsrc = 0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_d(input vec_t v);
        ValidD = v.valid; RD1D = v.rd1; RD2D = v.rd2; ImmExtD = v.imm; PCD = v.pc;
        Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; ALUControlD = v.aluc;
        ALUSrcD = v.alusrc; RegWriteD = v.regw; MemWriteD = v.memw;
        ResultSrcD = v.rsrc; FlushE = v.flush;
    endtask

    task automatic apply_mw(input vec_t v);
        ALUResultM = v.alu_m; RdM = v.rd_m; RegWriteM = v.regw_m;
        ResultW = v.res_w; RdW = v.rd_w; RegWriteW = v.regw_w;
    endtask

    task automatic check_e(input string tag, input vec_t v);
        chk({tag, ".SrcAE"}, SrcAE, v.x_srca);
        chk({tag, ".SrcBE"}, SrcBE, v.x_srcb);
        chk({tag, ".WriteDataE"}, WriteDataE, v.x_wdata);
        chk({tag, ".ValidE"}, 64'(ValidE), 64'(v.x_valid));
        chk({tag, ".RegWriteE"}, 64'(RegWriteE), 64'(v.x_regw));
        chk({tag, ".MemWriteE"}, 64'(MemWriteE), 64'(v.x_memw));
        chk({tag, ".RdE"}, 64'(RdE), 64'(v.x_rd));
        chk({tag, ".ALUControlE"}, 64'(ALUControlE), 64'(v.x_aluc));
        chk({tag, ".ResultSrcE"}, 64'(ResultSrcE), 64'(v.x_rsrc));
        chk({tag, ".PCE"}, PCE, v.x_pc);
        chk({tag, ".ImmExtE"}, ImmExtE, v.x_imm);
    endtask

    vec_t vt[10];
    vec_t v, ld, use_v, nomw;

    initial begin
        // ADDI x5,x0,7
        v = zv(); v.valid = 1; v.imm = 7; v.alusrc = 1; v.rd = 5; v.regw = 1; v.pc = 64'h100;
        v.x_srcb = 7; v.x_valid = 1; v.x_regw = 1; v.x_rd = 5; v.x_pc = 64'h100; v.x_imm = 7;
        vt[0] = v;
        // ADD x6,x5,x5 with x5 forwarded from MEM
        v = zv(); v.valid = 1; v.rs1 = 5; v.rs2 = 5; v.rd1 = 64'h99; v.rd2 = 64'h99; v.rd = 6;
        v.regw = 1; v.pc = 64'h104; v.regw_m = 1; v.rd_m = 5; v.alu_m = 7;
        v.x_srca = 7; v.x_srcb = 7; v.x_wdata = 7; v.x_valid = 1; v.x_regw = 1; v.x_rd = 6;
        v.x_pc = 64'h104;
        vt[1] = v;
        // MEM beats WB for the same register
        v = zv(); v.valid = 1; v.rs1 = 3; v.rd1 = 64'h33; v.imm = 64'h40; v.alusrc = 1; v.rd = 7;
        v.regw = 1; v.aluc = 4'b0010; v.regw_m = 1; v.rd_m = 3; v.alu_m = 64'h11;
        v.regw_w = 1; v.rd_w = 3; v.res_w = 64'h22;
        v.x_srca = 64'h11; v.x_srcb = 64'h40; v.x_valid = 1; v.x_regw = 1; v.x_rd = 7;
        v.x_aluc = 4'b0010; v.x_imm = 64'h40;
        vt[2] = v;
        // WB-only match on Rs2, MEM writes an unrelated register
        v = zv(); v.valid = 1; v.rs1 = 2; v.rs2 = 9; v.rd1 = 5; v.rd2 = 6; v.rd = 10; v.regw = 1;
        v.regw_m = 1; v.rd_m = 4; v.alu_m = 64'hAA; v.regw_w = 1; v.rd_w = 9; v.res_w = 64'h77;
        v.x_srca = 5; v.x_srcb = 64'h77; v.x_wdata = 64'h77; v.x_valid = 1; v.x_regw = 1; v.x_rd = 10;
        vt[3] = v;
        // x0 is never forwarded
        v = zv(); v.valid = 1; v.rd = 11; v.regw = 1;
        v.regw_m = 1; v.rd_m = 0; v.alu_m = 64'hFF; v.regw_w = 1; v.rd_w = 0; v.res_w = 64'hEE;
        v.x_valid = 1; v.x_regw = 1; v.x_rd = 11;
        vt[4] = v;
        // Matching index but write-enable low: no forwarding
        v = zv(); v.valid = 1; v.rs1 = 8; v.rd1 = 64'h123; v.rs2 = 1; v.rd2 = 64'h456; v.rd = 12;
        v.rd_m = 8; v.alu_m = 64'h999; v.rd_w = 1; v.res_w = 64'h888;
        v.x_srca = 64'h123; v.x_srcb = 64'h456; v.x_wdata = 64'h456; v.x_valid = 1; v.x_rd = 12;
        vt[5] = v;
        // Store flushed: bubble, and Rs1E=0 so MEM match on x1 must not leak through
        v = zv(); v.valid = 1; v.memw = 1; v.rd = 12; v.rs1 = 1; v.rs2 = 2; v.rd1 = 64'h10;
        v.rd2 = 64'h20; v.imm = 4; v.pc = 64'h200; v.aluc = 4'b0111; v.flush = 1;
        v.regw_m = 1; v.rd_m = 1; v.alu_m = 64'h55;
        vt[6] = v;
        // ValidD=0 loads a bubble
        v.flush = 0; v.valid = 0;
        vt[7] = v;
        // Store, address from imm, store data forwarded from MEM
        v = zv(); v.valid = 1; v.rs1 = 1; v.rd1 = 64'h1000; v.rs2 = 2; v.rd2 = 64'h20; v.imm = 8;
        v.alusrc = 1; v.memw = 1; v.regw_m = 1; v.rd_m = 2; v.alu_m = 64'hBEEF;
        v.x_srca = 64'h1000; v.x_srcb = 8; v.x_wdata = 64'hBEEF; v.x_valid = 1; v.x_memw = 1;
        v.x_imm = 8;
        vt[8] = v;
        // JAL-like: PC+4 result, opcode and PC pass through bit-exact
        v = zv(); v.valid = 1; v.pc = 64'h8000_0004; v.rsrc = 2'b10; v.rd = 1; v.regw = 1;
        v.aluc = 4'b1101;
        v.x_valid = 1; v.x_regw = 1; v.x_rd = 1; v.x_aluc = 4'b1101; v.x_rsrc = 2'b10;
        v.x_pc = 64'h8000_0004;
        vt[9] = v;

        nomw = zv();

        // Reset wins over a valid decode
        rst_n = 0;
        apply_d(vt[9]); apply_mw(nomw);
        repeat (2) @(posedge clk);
        #1;
        check_e("reset", nomw);
        chk("reset.StallD", 64'(StallD), 64'd0);

        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply_d(vt[i]); apply_mw(nomw);
            @(posedge clk);
            #1;
            ValidD = 0; FlushE = 0;
            apply_mw(vt[i]);
            #1;
            check_e($sformatf("vec%0d", i), vt[i]);
            chk($sformatf("vec%0d.StallD", i), 64'(StallD), 64'd0);
        end

        // Load-use: LD x4,0(x1) followed by SH2ADD x7,x4,x3
        ld = zv(); ld.valid = 1; ld.rs1 = 1; ld.rd1 = 64'h100; ld.alusrc = 1; ld.rsrc = 2'b01;
        ld.regw = 1; ld.rd = 4;
        use_v = zv(); use_v.valid = 1; use_v.rs1 = 4; use_v.rs2 = 3; use_v.rd1 = 64'hDEAD;
        use_v.rd2 = 64'h30; use_v.aluc = 4'b1010; use_v.rd = 7; use_v.regw = 1;

        @(negedge clk); apply_d(ld); apply_mw(nomw);
        @(negedge clk); apply_d(use_v);
        #1 chk("lu.StallD_hi", 64'(StallD), 64'd1);
        @(posedge clk); #1;
        chk("lu.bubble_ValidE", 64'(ValidE), 64'd0);
        chk("lu.bubble_RegWriteE", 64'(RegWriteE), 64'd0);
        chk("lu.StallD_one_cycle", 64'(StallD), 64'd0);
        @(posedge clk); #1;
        RegWriteW = 1; RdW = 4; ResultW = 64'hCAFE;
        #1;
        chk("lu.SrcAE_from_W", SrcAE, 64'hCAFE);
        chk("lu.SrcBE", SrcBE, 64'h30);
        chk("lu.ValidE", 64'(ValidE), 64'd1);
        chk("lu.ALUControlE", 64'(ALUControlE), 64'hA);
        chk("lu.StallD_after", 64'(StallD), 64'd0);

        // Flush coinciding with a stall yields a single bubble
        @(negedge clk); apply_d(ld); apply_mw(nomw);
        @(negedge clk); apply_d(use_v); FlushE = 1;
        #1 chk("fs.StallD_hi", 64'(StallD), 64'd1);
        @(posedge clk); #1;
        FlushE = 0;
        #1;
        chk("fs.ValidE", 64'(ValidE), 64'd0);
        chk("fs.StallD", 64'(StallD), 64'd0);
        @(posedge clk); #1;
        chk("fs.next_ValidE", 64'(ValidE), 64'd1);
        chk("fs.next_RdE", 64'(RdE), 64'd7);

        // Reset during a pending load-use stall
        @(negedge clk); apply_d(ld);
        @(negedge clk); apply_d(use_v);
        #1 chk("rs.StallD_hi", 64'(StallD), 64'd1);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        #1;
        check_e("rs", nomw);
        chk("rs.StallD", 64'(StallD), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 64, datapath width; all data ports below are XLEN bits.
REQ-002 clk  input  1  rising-edge clock; the block uses this single clock.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ValidD  input  1  decode slot holds a real instruction.
REQ-005 RD1D, RD2D, ImmExtD, PCD  input  XLEN  register-file reads, extended immediate, PC.
REQ-006 Rs1D, Rs2D, RdD  input  5  source and destination register indices.
REQ-007 ALUControlD  input  4  ALU opcode, passed through unchanged.
REQ-008 ALUSrcD, RegWriteD, MemWriteD  input  1  SrcB select (1=imm), writeback enable, store enable.
REQ-009 ResultSrcD  input  2  00=ALU, 01=load, 10=PC+4.
REQ-010 FlushE  input  1  branch/jump resolved taken; kill the instruction entering E.
REQ-011 ALUResultM, RdM, RegWriteM  input  XLEN/5/1  MEM-stage forwarding source.
REQ-012 ResultW, RdW, RegWriteW  input  XLEN/5/1  WB-stage forwarding source.
REQ-013 SrcAE, SrcBE, WriteDataE  output  XLEN  forwarded ALU operands and store data.
REQ-014 ALUControlE  output  4; ValidE, RegWriteE, MemWriteE  output  1 each; ResultSrcE  output  2; RdE  output  5; PCE, ImmExtE  output  XLEN.
REQ-015 StallD  output  1  load-use hazard; upstream IF/ID SHALL hold.

Function
REQ-016 E-stage register SHALL capture all D-stage fields on each rising clk edge unless a bubble is inserted.
REQ-017 Bubble SHALL be inserted when FlushE=1 or StallD=1: ValidE, RegWriteE, MemWriteE cleared; ResultSrcE, ALUControlE, RdE, data fields zeroed.
REQ-018 ValidD=0 SHALL load a bubble identical to REQ-017.
REQ-019 StallD SHALL be combinational: 1 when ValidE=1, ResultSrcE=01, RegWriteE=1, RdE!=0, ValidD=1, and (RdE==Rs1D or RdE==Rs2D).
REQ-020 FlushE and StallD together SHALL produce one bubble; no extra cycle.
REQ-021 Load-use stall SHALL last exactly one cycle; next cycle the load is in M and forwarding resolves the hazard.
REQ-022 Forward select for each source (Rs1E, Rs2E registered internally) SHALL be: MEM if RegWriteM=1, RdM!=0, RdM==RsE; else WB if RegWriteW=1, RdW!=0, RdW==RsE; else register value.
REQ-023 MEM SHALL take priority over WB when both match.
REQ-024 Index 0 SHALL never be forwarded; x0 reads pass RD1E/RD2E (zero) through.
REQ-025 SrcAE = forwarded Rs1 value; WriteDataE = forwarded Rs2 value; SrcBE = ImmExtE when ALUSrcE=1, else forwarded Rs2 value.
REQ-026 Forwarding and SrcAE/SrcBE/WriteDataE SHALL be combinational from E registers and M/W inputs (zero added latency).
REQ-027 Latency D to E SHALL be exactly one clk cycle; ALUControlE is the registered ALUControlD bit-exact.
REQ-028 Rs1E/Rs2E of a bubble SHALL be 0 so no forwarding match occurs.

Reset
REQ-029 While rst_n=0 at a rising edge, all E registers SHALL load the bubble value of REQ-017, including Rs1E/Rs2E=0.
REQ-030 After reset, StallD=0 and SrcAE/SrcBE/WriteDataE=0 until a valid instruction is captured.
REQ-031 Reset asserted mid-stall SHALL clear the pending load in E; StallD=0 the following cycle.

Verification
REQ-032 ADDI x5,x0,7 then ADD x6,x5,x5 back-to-back, RegWriteM=1, RdM=5, ALUResultM=7 -> SrcAE=7, SrcBE=7, ALUControlE=0000.
REQ-033 RdM=3 ALUResultM=0x11 and RdW=3 ResultW=0x22, Rs1E=3 -> SrcAE=0x11 (MEM priority).
REQ-034 LD x4 in E (ResultSrcE=01), D has SH2ADD using x4 -> StallD=1 one cycle, bubble in E (RegWriteE=0), then SH2ADD enters with SrcAE=ResultW.
REQ-035 FlushE=1 while D holds a store -> next cycle MemWriteE=0, ValidE=0, RdE=0.
REQ-036 RdM=0, RegWriteM=1, ALUResultM=0xFF, Rs1E=0 -> SrcAE=RD1E=0.
REQ-037 rst_n=0 for one edge while a load is in E with StallD=1 -> next cycle ValidE=0, StallD=0, all outputs zero.
